// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and register-index constants.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Combinational load-use comparator: flags an ID source that depends on a load currently in EX.
module hazard_detect_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic                 mem_read,
    input  logic [REG_IDX_W-1:0] write_reg_idx,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used && (rs1_idx == write_reg_idx);
    assign rs2_hit  = rs2_used && (rs2_idx == write_reg_idx);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = mem_read && (write_reg_idx != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline with memory-wait FSM,
// memory-timeout error and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int PERF_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_idx_ID,
    input  logic [REG_IDX_W-1:0] rs2_idx_ID,
    input  logic                 rs1_used_ID,
    input  logic                 rs2_used_ID,
    input  logic                 mem_read_EX,
    input  logic [REG_IDX_W-1:0] write_reg_idx_EX,
    input  logic                 branch_taken_EX,
    input  logic                 mem_req_MEM,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_bubble,
    output logic                 mem_timeout,
    output logic [PERF_W-1:0]    stall_cycles
);

    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_nx;
    logic            timeout_q;
    logic            timeout_nx;
    logic            load_use;
    logic            mem_stall;

    hazard_detect_unit u_hazard_detect (
        .rs1_idx       (rs1_idx_ID),
        .rs2_idx       (rs2_idx_ID),
        .rs1_used      (rs1_used_ID),
        .rs2_used      (rs2_used_ID),
        .mem_read      (mem_read_EX),
        .write_reg_idx (write_reg_idx_EX),
        .load_use      (load_use)
    );

    // A dropped request releases the wait exactly like mem_ready does
    assign mem_stall   = mem_req_MEM && !mem_ready;
    assign mem_timeout = timeout_q;

    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst) begin
            if (state == ERROR) begin
                mem_wb_bubble = 1'b1;
            end else if (mem_stall) begin
                mem_wb_bubble = 1'b1;
            end else if (branch_taken_EX) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        timeout_nx  = timeout_q;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nx    = MEM_WAIT;
                    wait_cnt_nx = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1)) begin
                    // The RUN cycle that entered the wait counts as the first stalled cycle
                    state_nx   = ERROR;
                    timeout_nx = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + WC_W'(1);
                end
            end
            default: begin
                state_nx = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            timeout_q    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_cnt_nx;
            timeout_q <= timeout_nx;
            if (!pc_en && (stall_cycles != {PERF_W{1'b1}})) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard queue of expected control vectors.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int T  = 4;
    localparam int PW = 4;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_timeout}
    localparam logic [7:0] C_RESET  = 8'b0000_0000;
    localparam logic [7:0] C_NORMAL = 8'b1101_0100;
    localparam logic [7:0] C_BRANCH = 8'b1111_1100;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_FREEZE = 8'b0000_0010;
    localparam logic [7:0] C_ERROR  = 8'b0000_0011;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_idx_ID, rs2_idx_ID, write_reg_idx_EX;
    logic          rs1_used_ID, rs2_used_ID, mem_read_EX, branch_taken_EX, mem_req_MEM, mem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
    logic          mem_wb_bubble, mem_timeout;
    logic [PW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(T), .PERF_W(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .rs1_idx_ID       (rs1_idx_ID),
        .rs2_idx_ID       (rs2_idx_ID),
        .rs1_used_ID      (rs1_used_ID),
        .rs2_used_ID      (rs2_used_ID),
        .mem_read_EX      (mem_read_EX),
        .write_reg_idx_EX (write_reg_idx_EX),
        .branch_taken_EX  (branch_taken_EX),
        .mem_req_MEM      (mem_req_MEM),
        .mem_ready        (mem_ready),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .if_id_flush      (if_id_flush),
        .id_ex_en         (id_ex_en),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_bubble    (mem_wb_bubble),
        .mem_timeout      (mem_timeout),
        .stall_cycles     (stall_cycles)
    );

    typedef struct {
        logic [7:0]    ctrl;
        logic [PW-1:0] stall;
        string         tag;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [PW-1:0] model_stall;
    logic [7:0]    ctrl_obs;

    assign ctrl_obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                       mem_wb_bubble, mem_timeout};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic mrd, input logic [4:0] wr,
                          input logic br, input logic req, input logic rdy);
        rs1_idx_ID       = rs1;
        rs2_idx_ID       = rs2;
        rs1_used_ID      = u1;
        rs2_used_ID      = u2;
        mem_read_EX      = mrd;
        write_reg_idx_EX = wr;
        branch_taken_EX  = br;
        mem_req_MEM      = req;
        mem_ready        = rdy;
    endtask

    // Inputs are already applied; the expected vector is queued, then checked mid-cycle.
    task automatic step(input logic [7:0] ctrl, input string tag);
        exp_t e;
        sb.push_back('{ctrl, model_stall, tag});
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_ctrl"}, ctrl_obs, e.ctrl);
            chk({e.tag, "_stall"}, 8'(stall_cycles), 8'(e.stall));
            if (!e.ctrl[7] && model_stall != {PW{1'b1}}) model_stall = model_stall + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("reset_ctrl", ctrl_obs, C_RESET);
        chk("reset_stall", 8'(stall_cycles), 8'd0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_stall = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        model_stall = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("por_ctrl", ctrl_obs, C_RESET);
        chk("por_state", 8'(dut.state), 8'(RUN));
        do_reset();

        step(C_NORMAL, "normal");
        set_in(5, 0, 1, 0, 1, 5, 0, 0, 0);
        step(C_LU, "lu_rs1");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(C_NORMAL, "lu_release");
        chk("lu_stall_one", 8'(stall_cycles), 8'd1);
        set_in(0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(C_NORMAL, "lu_x0");
        set_in(3, 9, 1, 1, 1, 9, 0, 0, 0);
        step(C_LU, "lu_rs2");
        set_in(3, 9, 1, 0, 1, 9, 0, 0, 0);
        step(C_NORMAL, "lu_rs2_unused");
        set_in(5, 0, 1, 0, 1, 5, 1, 0, 0);
        step(C_BRANCH, "branch_over_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(C_NORMAL, "mem_ready_same");
        chk("mem_ready_same_state", 8'(dut.state), 8'(RUN));

        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(C_FREEZE, "memwait_freeze");
            chk("memwait_state", 8'(dut.state), 8'(MEM_WAIT));
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(C_NORMAL, "memwait_release");
        chk("memwait_back_run", 8'(dut.state), 8'(RUN));
        chk("memwait_stall_three", 8'(stall_cycles), 8'd3);

        set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(C_FREEZE, "br_freeze0");
        step(C_FREEZE, "br_freeze1");
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(C_BRANCH, "br_release");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(C_NORMAL, "br_after");

        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(C_FREEZE, "req_drop_freeze");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(C_NORMAL, "req_drop_release");
        chk("req_drop_state", 8'(dut.state), 8'(RUN));

        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < T; i++) begin
            step(C_FREEZE, "to_freeze");
            if (i == T - 2) chk("to_not_early", 8'(dut.state), 8'(MEM_WAIT));
        end
        chk("to_state_error", 8'(dut.state), 8'(ERROR));
        step(C_ERROR, "to_error");
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(C_ERROR, "to_sticky0");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(C_ERROR, "to_sticky1");
        for (int i = 0; i < 20; i++) step(C_ERROR, "sat");
        chk("sat_hold", 8'(stall_cycles), 8'd15);

        #3 rst = 1'b0;
        #1;
        chk("async_rst_timeout", 8'(mem_timeout), 8'd0);
        chk("async_rst_state", 8'(dut.state), 8'(RUN));
        chk("async_rst_stall", 8'(stall_cycles), 8'd0);
        chk("async_rst_ctrl", ctrl_obs, C_RESET);
        @(posedge clk);
        #2 rst = 1'b1;
        model_stall = '0;
        @(posedge clk);
        #1;
        step(C_NORMAL, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
